// File: rtl/regfile_write_arbiter.sv
// Two-requester write arbiter for a 32-entry register file: round-robin grant
// on contention, one-cycle ISSUE with a registered one-hot write enable.
// Optional contention counter guarded by REGARB_CONFLICT_COUNT_EN.
module regfile_write_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic [4:0]  req0_addr,
   input  logic [31:0] req0_data,
   input  logic        req1_valid,
   input  logic [4:0]  req1_addr,
   input  logic [31:0] req1_data,
   output logic        req0_ready,
   output logic        req1_ready,
   output logic [31:0] wr_enables,
   output logic [31:0] wr_data,
   output logic        grant_id,
   output logic [15:0] conflict_count
);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t      state;
   state_t      state_next;
   logic        last_grant;
   logic        both_valid;
   logic        any_valid;
   logic        pick1;
   logic        accept;
   logic [4:0]  sel_addr;
   logic [31:0] sel_data;

   // Register 0 is hard-wired, so its enable bit is never driven.
   function automatic logic [31:0] decode_addr(input logic [4:0] addr);
      logic [31:0] onehot;
      onehot = '0;
      for (int unsigned n = 1; n < 32; n++) begin
         if (addr == 5'(n))
            onehot[n] = 1'b1;
      end
      return onehot;
   endfunction

   assign both_valid = req0_valid & req1_valid;
   assign any_valid  = req0_valid | req1_valid;
   // last_grant records the previous winner; contention goes to the other one.
   assign pick1      = both_valid ? ~last_grant : req1_valid;
   assign accept     = req0_ready | req1_ready;
   assign sel_addr   = pick1 ? req1_addr : req0_addr;
   assign sel_data   = pick1 ? req1_data : req0_data;

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (any_valid) state_next = ISSUE;
         ISSUE:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (state == IDLE && !reset && any_valid) begin
         req0_ready = ~pick1;
         req1_ready = pick1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_enables <= '0;
         wr_data    <= '0;
         grant_id   <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         wr_enables <= '0;
         if (accept) begin
            wr_enables <= decode_addr(sel_addr);
            wr_data    <= sel_data;
            grant_id   <= pick1;
            last_grant <= pick1;
         end
      end
   end

`ifdef REGARB_CONFLICT_COUNT_EN
   always_ff @(posedge clk) begin
      if (reset)
         conflict_count <= '0;
      else if (state == IDLE && both_valid && conflict_count != '1)
         conflict_count <= conflict_count + 16'd1;
   end
`else
   assign conflict_count = '0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios followed by
// randomized traffic compared against a transaction-level reference model.
module tb_regfile_write_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic [4:0]  req0_addr, req1_addr;
   logic [31:0] req0_data, req1_data;
   logic        req0_ready, req1_ready;
   logic [31:0] wr_enables, wr_data;
   logic        grant_id;
   logic [15:0] conflict_count;

   int checks   = 0;
   int failures = 0;

   // Reference model: "busy" means a write was taken last edge and is issuing now.
   bit          m_busy;
   bit          m_last;
   logic [31:0] m_en, m_data;
   logic        m_id;
   int          m_cnt;

   regfile_write_arbiter dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .wr_enables(wr_enables), .wr_data(wr_data), .grant_id(grant_id),
      .conflict_count(conflict_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Who the model says should win this cycle: -1 none, else requester id.
   function automatic int model_winner();
      if (reset || m_busy) return -1;
      if (req0_valid && req1_valid) return m_last ? 0 : 1;
      if (req0_valid) return 0;
      if (req1_valid) return 1;
      return -1;
   endfunction

   function automatic logic [15:0] model_count();
`ifdef REGARB_CONFLICT_COUNT_EN
      return 16'(m_cnt);
`else
      return 16'h0000;
`endif
   endfunction

   // One clock: check combinational ready, take the edge, update model, check registers.
   task automatic step();
      int w;
      #2;
      w = model_winner();
      chk("req0_ready", 32'(req0_ready), 32'(w == 0));
      chk("req1_ready", 32'(req1_ready), 32'(w == 1));
      @(posedge clk);
      if (reset) begin
         m_busy = 0; m_last = 1; m_en = '0; m_data = '0; m_id = 0; m_cnt = 0;
      end else begin
         if (!m_busy && req0_valid && req1_valid && m_cnt < 65535) m_cnt++;
         if (w >= 0) begin
            logic [4:0] a;
            a      = (w == 1) ? req1_addr : req0_addr;
            m_en   = (a == 0) ? 32'h0 : (32'h1 << a);
            m_data = (w == 1) ? req1_data : req0_data;
            m_id   = (w == 1);
            m_last = (w == 1);
            m_busy = 1;
         end else begin
            m_en   = '0;
            m_busy = 0;
         end
      end
      #1;
      chk("wr_enables", wr_enables, m_en);
      chk("wr_data", wr_data, m_data);
      chk("grant_id", 32'(grant_id), 32'(m_id));
      chk("conflict_count", 32'(conflict_count), 32'(model_count()));
   endtask

   task automatic idle_inputs();
      req0_valid = 0; req1_valid = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      step();
      step();
      reset = 0;
   endtask

   initial begin
      logic [31:0] exp_en [4];
      reset = 1;
      idle_inputs();
      req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
      m_busy = 0; m_last = 1; m_en = '0; m_data = '0; m_id = 0; m_cnt = 0;
      @(posedge clk); #1;

      // Reset state
      do_reset();
      chk("reset_wr_enables", wr_enables, 32'h0);
      chk("reset_wr_data", wr_data, 32'h0);
      chk("reset_grant_id", 32'(grant_id), 32'h0);
      chk("reset_count", 32'(conflict_count), 32'h0);

      // Single write
      req0_valid = 1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
      step();
      chk("single_en", wr_enables, 32'h0000_0020);
      chk("single_data", wr_data, 32'hDEADBEEF);
      chk("single_id", 32'(grant_id), 32'h0);
      idle_inputs();
      step();
      chk("single_en_clear", wr_enables, 32'h0);
      chk("single_data_hold", wr_data, 32'hDEADBEEF);

      // Contention from reset, plus counter over 8 contended cycles
      do_reset();
      req0_valid = 1; req0_addr = 5'd1; req0_data = 32'h1111_1111;
      req1_valid = 1; req1_addr = 5'd2; req1_data = 32'h2222_2222;
      exp_en[0] = 32'h2; exp_en[1] = 32'h4; exp_en[2] = 32'h2; exp_en[3] = 32'h4;
      for (int i = 0; i < 8; i++) begin
         step();
         if (i % 2 == 0) begin
            chk("contend_en", wr_enables, exp_en[i / 2]);
            chk("contend_id", 32'(grant_id), 32'((i / 2) % 2));
         end else begin
            chk("contend_gap", wr_enables, 32'h0);
         end
      end
`ifdef REGARB_CONFLICT_COUNT_EN
      chk("count_8cyc", 32'(conflict_count), 32'd4);
`else
      chk("count_8cyc", 32'(conflict_count), 32'd0);
`endif

      // Zero register write by req1, held valid
      idle_inputs();
      req1_valid = 1; req1_addr = 5'd0; req1_data = 32'hFFFFFFFF;
      step();
      chk("zero_en", wr_enables, 32'h0);
      chk("zero_id", 32'(grant_id), 32'h1);
      chk("zero_data", wr_data, 32'hFFFFFFFF);
      step();
      #1;
      chk("zero_ready_back", 32'(req1_ready), 32'h1);
      step();

      // Reset during ISSUE aborts, next conflict goes to req0
      idle_inputs();
      step();
      req1_valid = 1; req1_addr = 5'd31; req1_data = 32'hA5A5_5A5A;
      step();
      chk("r31_en", wr_enables, 32'h8000_0000);
      idle_inputs();
      reset = 1;
      step();
      reset = 0;
      chk("abort_en", wr_enables, 32'h0);
      req0_valid = 1; req1_valid = 1; req0_addr = 5'd3; req1_addr = 5'd4;
      #1;
      chk("post_reset_winner", 32'(req0_ready), 32'h1);
      step();
      chk("post_reset_en", wr_enables, 32'h8);

      // Data stability after acceptance
      idle_inputs();
      step();
      req0_valid = 1; req0_addr = 5'd7; req0_data = 32'h1234_5678;
      step();
      req0_valid = 0; req0_data = 32'h8765_4321;
      step();
      chk("stable_data", wr_data, 32'h1234_5678);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         reset      = ($urandom_range(0, 49) == 0);
         req0_valid = $urandom_range(0, 2) != 0;
         req1_valid = $urandom_range(0, 2) != 0;
         req0_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         req1_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         req0_data  = $urandom;
         req1_data  = $urandom;
         step();
      end
      reset = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-002 The block SHALL have a single clock domain, and all state SHALL update only on the rising edge of clk.
REQ-003 clk  input  1  rising-edge clock shared with the register file.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 req0_valid / req1_valid  input  1 each  requester i presents a write.
REQ-006 req0_addr / req1_addr  input  5 each  destination register index.
REQ-007 req0_data / req1_data  input  32 each  write data.
REQ-008 req0_ready / req1_ready  output  1 each  combinational grant; a write is accepted on a cycle where valid and ready are both high.
REQ-009 wr_enables  output  32  registered one-hot write-enable vector, bit n driving register n.
REQ-010 wr_data  output  32  registered data bus to all registers.
REQ-011 grant_id  output  1  registered ID of the requester whose write is currently issuing.
REQ-012 conflict_count  output  16  saturating count of contention cycles (see Configuration).

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and ISSUE.
REQ-014 In IDLE with no valid request, all ready signals SHALL be 0 and the state SHALL remain IDLE.
REQ-015 In IDLE with exactly one valid request, that requester's ready SHALL be 1, the other's ready SHALL be 0, and the state SHALL go to ISSUE.
REQ-016 In IDLE with both requests valid, ready SHALL go to the requester not recorded in last_grant, and last_grant SHALL update to the winner.
REQ-017 Single-request grants SHALL also update last_grant.
REQ-018 On acceptance, addr, data and ID SHALL be captured.
REQ-019 In the ISSUE cycle, wr_enables SHALL have exactly the captured addr bit set, wr_data SHALL equal the captured data, and grant_id SHALL equal the captured ID.
REQ-020 The ISSUE state SHALL last exactly 1 cycle and then return to IDLE.
REQ-021 Both ready signals SHALL be 0 in ISSUE, giving a maximum throughput of 1 write per 2 cycles.
REQ-022 Latency SHALL be 1 cycle: a write accepted at edge k SHALL have wr_enables asserted during the cycle after edge k.
REQ-023 Outside ISSUE, wr_enables SHALL be 32'h0, while wr_data and grant_id hold their last values.
REQ-024 A write to address 0 SHALL be accepted and SHALL pass through ISSUE, but wr_enables SHALL stay 32'h0.
REQ-025 A requester that drops valid without receiving ready SHALL lose nothing, and no state SHALL change.
REQ-026 Address and data SHALL be sampled only at acceptance, so later input changes SHALL not affect the issuing write.

Reset
REQ-027 While reset is high at a clk edge, the following SHALL apply: state=IDLE, wr_enables=0, wr_data=0, grant_id=0, last_grant=1 (so req0 wins the first conflict), conflict_count=0.
REQ-028 Reset asserted during ISSUE SHALL abort the write: wr_enables SHALL be 0 from the following cycle onward.
REQ-029 Ready SHALL be 0 on any cycle where reset is high.

Configuration
REQ-030 When REGARB_CONFLICT_COUNT_EN is defined, conflict_count SHALL increment by 1 on each IDLE cycle where both requests are valid.
REQ-031 When REGARB_CONFLICT_COUNT_EN is defined, conflict_count SHALL saturate at 16'hFFFF.
REQ-032 When REGARB_CONFLICT_COUNT_EN is undefined, the counter logic SHALL be absent and conflict_count SHALL be tied to 16'h0000.

Verification
REQ-033 Single write: req0 addr=5, data=32'hDEADBEEF for one accept -> next cycle wr_enables=32'h0000_0020, wr_data=32'hDEADBEEF, grant_id=0; the cycle after that, wr_enables=0.
REQ-034 Contention: both valid continuously (req0 addr=1, req1 addr=2) from reset -> grants in order req0, req1, req0, req1; wr_enables sequence 0x2, 0x4, 0x2, 0x4 on alternating cycles.
REQ-035 Zero register: req1 addr=0, data=32'hFFFFFFFF -> ISSUE occurs with grant_id=1 and wr_enables=0; req1_ready returns 2 cycles later.
REQ-036 Reset in ISSUE: accept a write to addr=31, assert reset at the ISSUE-cycle edge -> wr_enables=0 afterward, state IDLE, the next conflict is won by req0.
REQ-037 Counter: with REGARB_CONFLICT_COUNT_EN defined, both valid for 8 cycles -> conflict_count=4; with it undefined -> conflict_count=0.
REQ-038 Data stability: change req0_data in the cycle after acceptance -> wr_data equals the originally accepted value.
